// File: rtl/alu_cmd_driver_if.sv
// Bundle of the command, response and ALU-bus signals around alu_cmd_driver.
// Handshake rule for cmd and rsp: a transfer happens on a rising clk edge where
// valid and ready are both high; the sender holds valid and its payload stable
// until that edge and never makes valid depend on ready.
interface alu_cmd_driver_if;
  logic       cmd_valid;
  logic       cmd_ready;
  logic [7:0] cmd_operands;
  logic [7:0] cmd_op;
  logic [7:0] alu_operands;
  logic [7:0] alu_op;
  logic [7:0] alu_result;
  logic       rsp_valid;
  logic       rsp_ready;
  logic [7:0] rsp_data;
  logic [7:0] rsp_op;
  logic       rsp_last;
  logic       rsp_err;

  // slave: the command driver itself
  modport slave (
    input  cmd_valid, cmd_operands, cmd_op, alu_result, rsp_ready,
    output cmd_ready, alu_operands, alu_op, rsp_valid, rsp_data, rsp_op,
           rsp_last, rsp_err
  );

  // master: command issuer, response consumer and the ALU tile
  modport master (
    output cmd_valid, cmd_operands, cmd_op, alu_result, rsp_ready,
    input  cmd_ready, alu_operands, alu_op, rsp_valid, rsp_data, rsp_op,
           rsp_last, rsp_err
  );
endinterface

// File: rtl/alu_cmd_driver.sv
// Command-side initiator for the 4-bit ALU tile: drives registered operand and
// opcode buses, waits a settle time, returns the captured result; 8'hFF sweeps ops.
module alu_cmd_driver #(
  parameter int unsigned SETTLE_CYCLES = 0,
  parameter int unsigned LAST_OP       = 12
) (
  input  logic              clk,
  input  logic              rst,
  alu_cmd_driver_if.slave   bus,
  output logic              busy,
  output logic [1:0]        state_o
);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_WAIT = 2'd1,
    S_RESP = 2'd2
  } state_e;

  localparam logic [3:0] SETTLE   = 4'(SETTLE_CYCLES);
  localparam logic [7:0] LAST     = 8'(LAST_OP);
  localparam logic [7:0] SWEEP_OP = 8'hFF;

  state_e     state_q, state_d;
  logic [3:0] cnt_q, cnt_d;
  logic       sweep_q, sweep_d;
  logic [7:0] alu_operands_q, alu_operands_d;
  logic [7:0] alu_op_q, alu_op_d;
  logic [7:0] rsp_data_q, rsp_data_d;
  logic [7:0] rsp_op_q, rsp_op_d;
  logic       rsp_last_q, rsp_last_d;
  logic       rsp_err_q, rsp_err_d;

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q        <= S_IDLE;
      cnt_q          <= 4'd0;
      sweep_q        <= 1'b0;
      alu_operands_q <= 8'd0;
      alu_op_q       <= 8'd0;
      rsp_data_q     <= 8'd0;
      rsp_op_q       <= 8'd0;
      rsp_last_q     <= 1'b0;
      rsp_err_q      <= 1'b0;
    end else begin
      state_q        <= state_d;
      cnt_q          <= cnt_d;
      sweep_q        <= sweep_d;
      alu_operands_q <= alu_operands_d;
      alu_op_q       <= alu_op_d;
      rsp_data_q     <= rsp_data_d;
      rsp_op_q       <= rsp_op_d;
      rsp_last_q     <= rsp_last_d;
      rsp_err_q      <= rsp_err_d;
    end
  end

  always_comb begin
    state_d        = state_q;
    cnt_d          = cnt_q;
    sweep_d        = sweep_q;
    alu_operands_d = alu_operands_q;
    alu_op_d       = alu_op_q;
    rsp_data_d     = rsp_data_q;
    rsp_op_d       = rsp_op_q;
    rsp_last_d     = rsp_last_q;
    rsp_err_d      = rsp_err_q;
    case (state_q)
      S_IDLE: begin
        // cmd_ready is high throughout IDLE outside reset, so valid alone is the handshake
        if (bus.cmd_valid) begin
          if (bus.cmd_op <= LAST || bus.cmd_op == SWEEP_OP) begin
            alu_operands_d = bus.cmd_operands;
            alu_op_d       = (bus.cmd_op == SWEEP_OP) ? 8'd0 : bus.cmd_op;
            sweep_d        = (bus.cmd_op == SWEEP_OP);
            cnt_d          = SETTLE;
            state_d        = S_WAIT;
          end else begin
            // illegal opcode: answer at once and leave the ALU buses alone
            rsp_data_d = 8'd0;
            rsp_err_d  = 1'b1;
            rsp_last_d = 1'b1;
            rsp_op_d   = bus.cmd_op;
            state_d    = S_RESP;
          end
        end
      end
      S_WAIT: begin
        if (cnt_q == 4'd0) begin
          rsp_data_d = bus.alu_result;
          rsp_op_d   = alu_op_q;
          rsp_err_d  = 1'b0;
          rsp_last_d = !sweep_q || (alu_op_q == LAST);
          state_d    = S_RESP;
        end else begin
          cnt_d = cnt_q - 4'd1;
        end
      end
      S_RESP: begin
        if (bus.rsp_ready) begin
          if (rsp_last_q) begin
            state_d = S_IDLE;
          end else begin
            alu_op_d = alu_op_q + 8'd1;
            cnt_d    = SETTLE;
            state_d  = S_WAIT;
          end
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_comb begin
    bus.cmd_ready = (state_q == S_IDLE) && !rst;
    bus.rsp_valid = (state_q == S_RESP);
    busy          = (state_q != S_IDLE);
    state_o       = state_q;
  end

  assign bus.alu_operands = alu_operands_q;
  assign bus.alu_op       = alu_op_q;
  assign bus.rsp_data     = rsp_data_q;
  assign bus.rsp_op       = rsp_op_q;
  assign bus.rsp_last     = rsp_last_q;
  assign bus.rsp_err      = rsp_err_q;

endmodule

// File: tb/tb_alu_cmd_driver.sv
// Directed bench for alu_cmd_driver: two instances (settle 0 and 3), each fed by
// a behavioural model of the 4-bit ALU tile.
module tb_alu_cmd_driver;

  logic clk;
  logic rst;
  int   errors;
  int   checks;

  alu_cmd_driver_if bus0 ();
  alu_cmd_driver_if bus3 ();
  logic       busy0, busy3;
  logic [1:0] state0, state3;

  alu_cmd_driver #(.SETTLE_CYCLES(0), .LAST_OP(12)) dut0 (
    .clk(clk), .rst(rst), .bus(bus0.slave), .busy(busy0), .state_o(state0)
  );
  alu_cmd_driver #(.SETTLE_CYCLES(3), .LAST_OP(12)) dut3 (
    .clk(clk), .rst(rst), .bus(bus3.slave), .busy(busy3), .state_o(state3)
  );

  // operand byte is {y, x}
  function automatic logic [7:0] alu_model(input logic [7:0] opnd, input logic [7:0] op);
    logic [7:0] x, y;
    x = {4'h0, opnd[3:0]};
    y = {4'h0, opnd[7:4]};
    case (op)
      8'd0:    return x + y;
      8'd1:    return x - y;
      8'd2:    return x * y;
      8'd3:    return (y == 8'd0) ? 8'd0 : x / y;
      8'd4:    return x & y;
      8'd5:    return x | y;
      8'd6:    return x ^ y;
      8'd7:    return {4'h0, ~(opnd[3:0] & opnd[7:4])};
      8'd8:    return {4'h0, ~(opnd[3:0] | opnd[7:4])};
      8'd9:    return ~opnd;
      8'd10:   return x >> y;
      8'd11:   return x << y;
      8'd12:   return {7'd0, (x < y)};
      default: return 8'd0;
    endcase
  endfunction

  assign bus0.alu_result = alu_model(bus0.alu_operands, bus0.alu_op);
  assign bus3.alu_result = alu_model(bus3.alu_operands, bus3.alu_op);

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic send_cmd(input int sel, input logic [7:0] opnd, input logic [7:0] op);
    if (sel == 0) begin
      bus0.cmd_valid = 1'b1; bus0.cmd_operands = opnd; bus0.cmd_op = op;
    end else begin
      bus3.cmd_valid = 1'b1; bus3.cmd_operands = opnd; bus3.cmd_op = op;
    end
    @(posedge clk); #1;
    bus0.cmd_valid = 1'b0;
    bus3.cmd_valid = 1'b0;
  endtask

  task automatic test_reset;
    rst = 1'b1;
    bus0.cmd_valid = 1'b1; bus0.cmd_operands = 8'h53; bus0.cmd_op = 8'd0;
    repeat (2) @(posedge clk);
    #1;
    checks++; if (bus0.cmd_ready !== 1'b0) begin errors++; $display("FAIL reset_cmd_ready got %b exp 0", bus0.cmd_ready); end
    checks++; if (bus0.rsp_valid !== 1'b0) begin errors++; $display("FAIL reset_rsp_valid got %b exp 0", bus0.rsp_valid); end
    checks++; if (bus0.alu_operands !== 8'h00) begin errors++; $display("FAIL reset_alu_operands got %h exp 00", bus0.alu_operands); end
    checks++; if (bus0.alu_op !== 8'h00) begin errors++; $display("FAIL reset_alu_op got %h exp 00", bus0.alu_op); end
    checks++; if (bus0.rsp_data !== 8'h00) begin errors++; $display("FAIL reset_rsp_data got %h exp 00", bus0.rsp_data); end
    checks++; if (bus0.rsp_op !== 8'h00) begin errors++; $display("FAIL reset_rsp_op got %h exp 00", bus0.rsp_op); end
    checks++; if ({bus0.rsp_last, bus0.rsp_err} !== 2'b00) begin errors++; $display("FAIL reset_last_err got %b exp 00", {bus0.rsp_last, bus0.rsp_err}); end
    checks++; if ({busy0, busy3} !== 2'b00) begin errors++; $display("FAIL reset_busy got %b exp 00", {busy0, busy3}); end
    checks++; if (state0 !== 2'd0) begin errors++; $display("FAIL reset_state got %0d exp 0", state0); end
    rst = 1'b0;
    bus0.cmd_valid = 1'b0;
    #1;
    checks++; if (bus0.cmd_ready !== 1'b1) begin errors++; $display("FAIL post_reset_cmd_ready got %b exp 1", bus0.cmd_ready); end
    @(posedge clk); #1;
    checks++; if (busy0 !== 1'b0) begin errors++; $display("FAIL reset_cmd_not_taken busy got %b exp 0", busy0); end
  endtask

  task automatic test_single_add;
    bus0.rsp_ready = 1'b0;
    checks++; if (bus0.cmd_ready !== 1'b1) begin errors++; $display("FAIL add_cmd_ready got %b exp 1", bus0.cmd_ready); end
    send_cmd(0, 8'h53, 8'd0);
    checks++; if (bus0.rsp_valid !== 1'b0) begin errors++; $display("FAIL add_early_valid got %b exp 0", bus0.rsp_valid); end
    @(posedge clk); #1;
    checks++; if (bus0.rsp_valid !== 1'b1) begin errors++; $display("FAIL add_valid got %b exp 1", bus0.rsp_valid); end
    checks++; if (bus0.rsp_data !== 8'h08) begin errors++; $display("FAIL add_data got %h exp 08", bus0.rsp_data); end
    checks++; if (bus0.rsp_op !== 8'h00) begin errors++; $display("FAIL add_op got %h exp 00", bus0.rsp_op); end
    checks++; if ({bus0.rsp_last, bus0.rsp_err} !== 2'b10) begin errors++; $display("FAIL add_last_err got %b exp 10", {bus0.rsp_last, bus0.rsp_err}); end
    bus0.rsp_ready = 1'b1;
    @(posedge clk); #1;
    bus0.rsp_ready = 1'b0;
    checks++; if (busy0 !== 1'b0 || bus0.cmd_ready !== 1'b1) begin errors++; $display("FAIL add_idle busy=%b cmd_ready=%b exp 0 1", busy0, bus0.cmd_ready); end
  endtask

  task automatic test_sweep;
    logic [7:0] exp_data [13];
    int cyc;
    exp_data = '{8'h09, 8'h03, 8'h12, 8'h02, 8'h02, 8'h07, 8'h05,
                 8'h0D, 8'h08, 8'hC9, 8'h00, 8'h30, 8'h00};
    bus0.rsp_ready = 1'b1;
    send_cmd(0, 8'h36, 8'hFF);
    for (int k = 0; k < 13; k++) begin
      cyc = 0;
      while (!bus0.rsp_valid && cyc < 10) begin @(posedge clk); #1; cyc++; end
      checks++;
      if (!bus0.rsp_valid) begin
        errors++; $display("FAIL sweep_timeout op %0d got no rsp_valid exp 1", k);
      end else begin
        if (bus0.rsp_data !== exp_data[k] || bus0.rsp_op !== 8'(k) ||
            bus0.rsp_last !== (k == 12) || bus0.rsp_err !== 1'b0) begin
          errors++;
          $display("FAIL sweep_rsp op %0d got data=%h op=%h last=%b err=%b exp data=%h op=%h last=%b err=0",
                   k, bus0.rsp_data, bus0.rsp_op, bus0.rsp_last, bus0.rsp_err, exp_data[k], 8'(k), (k == 12));
        end
      end
      @(posedge clk); #1;
    end
    checks++; if (busy0 !== 1'b0) begin errors++; $display("FAIL sweep_busy_end got %b exp 0", busy0); end
    bus0.rsp_ready = 1'b0;
  endtask

  task automatic test_backpressure;
    bus0.rsp_ready = 1'b0;
    send_cmd(0, 8'h36, 8'd2);
    @(posedge clk); #1;
    for (int i = 0; i < 5; i++) begin
      checks++;
      if (bus0.rsp_valid !== 1'b1 || bus0.rsp_data !== 8'h12 || bus0.alu_op !== 8'd2 ||
          bus0.alu_operands !== 8'h36 || bus0.cmd_ready !== 1'b0) begin
        errors++;
        $display("FAIL bp_hold cyc %0d got valid=%b data=%h alu_op=%h opnd=%h cmd_ready=%b exp 1 12 02 36 0",
                 i, bus0.rsp_valid, bus0.rsp_data, bus0.alu_op, bus0.alu_operands, bus0.cmd_ready);
      end
      @(posedge clk); #1;
    end
    bus0.rsp_ready = 1'b1;
    @(posedge clk); #1;
    bus0.rsp_ready = 1'b0;
    checks++; if (busy0 !== 1'b0 || bus0.cmd_ready !== 1'b1) begin errors++; $display("FAIL bp_release busy=%b cmd_ready=%b exp 0 1", busy0, bus0.cmd_ready); end
  endtask

  task automatic test_illegal;
    int cyc;
    bus0.rsp_ready = 1'b1;
    send_cmd(0, 8'h36, 8'd5);
    cyc = 0;
    while (busy0 && cyc < 10) begin @(posedge clk); #1; cyc++; end
    checks++; if (busy0 !== 1'b0) begin errors++; $display("FAIL illegal_prior_timeout busy got %b exp 0", busy0); end
    bus0.rsp_ready = 1'b0;
    send_cmd(0, 8'hAA, 8'h20);
    checks++; if (bus0.rsp_valid !== 1'b1) begin errors++; $display("FAIL illegal_valid got %b exp 1", bus0.rsp_valid); end
    checks++; if (bus0.rsp_data !== 8'h00 || bus0.rsp_op !== 8'h20) begin errors++; $display("FAIL illegal_data_op got %h %h exp 00 20", bus0.rsp_data, bus0.rsp_op); end
    checks++; if ({bus0.rsp_err, bus0.rsp_last} !== 2'b11) begin errors++; $display("FAIL illegal_err_last got %b exp 11", {bus0.rsp_err, bus0.rsp_last}); end
    checks++; if (bus0.alu_op !== 8'd5 || bus0.alu_operands !== 8'h36) begin errors++; $display("FAIL illegal_alu_bus got %h %h exp 05 36", bus0.alu_op, bus0.alu_operands); end
    bus0.rsp_ready = 1'b1;
    @(posedge clk); #1;
    bus0.rsp_ready = 1'b0;
    checks++; if (busy0 !== 1'b0) begin errors++; $display("FAIL illegal_idle busy got %b exp 0", busy0); end
  endtask

  task automatic test_settle3;
    bus3.rsp_ready = 1'b0;
    send_cmd(3, 8'h52, 8'd1);
    for (int i = 1; i <= 3; i++) begin
      @(posedge clk); #1;
      checks++; if (bus3.rsp_valid !== 1'b0) begin errors++; $display("FAIL settle_early cyc %0d got %b exp 0", i, bus3.rsp_valid); end
    end
    @(posedge clk); #1;
    checks++; if (bus3.rsp_valid !== 1'b1) begin errors++; $display("FAIL settle_valid got %b exp 1", bus3.rsp_valid); end
    checks++; if (bus3.rsp_data !== 8'hFD) begin errors++; $display("FAIL settle_data got %h exp FD", bus3.rsp_data); end
    bus3.rsp_ready = 1'b1;
    @(posedge clk); #1;
    bus3.rsp_ready = 1'b0;
    checks++; if (busy3 !== 1'b0) begin errors++; $display("FAIL settle_idle busy got %b exp 0", busy3); end
  endtask

  task automatic test_reset_mid_sweep;
    int  cyc;
    bit  found;
    bit  stray;
    bus0.rsp_ready = 1'b1;
    send_cmd(0, 8'h36, 8'hFF);
    found = 1'b0;
    cyc = 0;
    while (!found && cyc < 40) begin
      if (bus0.rsp_valid && bus0.rsp_op == 8'd4) found = 1'b1;
      else begin @(posedge clk); #1; cyc++; end
    end
    checks++; if (!found) begin errors++; $display("FAIL midrst_timeout got no op4 rsp exp op4 rsp"); end
    @(posedge clk); #1;
    rst = 1'b1;
    @(posedge clk); #1;
    checks++; if (bus0.rsp_valid !== 1'b0 || busy0 !== 1'b0 || state0 !== 2'd0) begin errors++; $display("FAIL midrst_state got valid=%b busy=%b state=%0d exp 0 0 0", bus0.rsp_valid, busy0, state0); end
    checks++; if (bus0.alu_operands !== 8'h00 || bus0.alu_op !== 8'h00) begin errors++; $display("FAIL midrst_alu_bus got %h %h exp 00 00", bus0.alu_operands, bus0.alu_op); end
    checks++; if (bus0.rsp_data !== 8'h00 || bus0.rsp_op !== 8'h00 || bus0.rsp_last !== 1'b0 || bus0.rsp_err !== 1'b0) begin errors++; $display("FAIL midrst_rsp got data=%h op=%h last=%b err=%b exp 00 00 0 0", bus0.rsp_data, bus0.rsp_op, bus0.rsp_last, bus0.rsp_err); end
    checks++; if (bus0.cmd_ready !== 1'b0) begin errors++; $display("FAIL midrst_cmd_ready_in_rst got %b exp 0", bus0.cmd_ready); end
    rst = 1'b0;
    #1;
    checks++; if (bus0.cmd_ready !== 1'b1) begin errors++; $display("FAIL midrst_cmd_ready_after got %b exp 1", bus0.cmd_ready); end
    stray = 1'b0;
    for (int i = 0; i < 10; i++) begin
      @(posedge clk); #1;
      if (bus0.rsp_valid || busy0) stray = 1'b1;
    end
    checks++; if (stray !== 1'b0) begin errors++; $display("FAIL midrst_no_resume got stray=%b exp 0", stray); end
    bus0.rsp_ready = 1'b0;
  endtask

  initial begin
    errors = 0;
    checks = 0;
    rst = 1'b1;
    bus0.cmd_valid = 1'b0; bus0.cmd_operands = 8'h00; bus0.cmd_op = 8'h00; bus0.rsp_ready = 1'b0;
    bus3.cmd_valid = 1'b0; bus3.cmd_operands = 8'h00; bus3.cmd_op = 8'h00; bus3.rsp_ready = 1'b0;
    test_reset;
    test_single_add;
    test_sweep;
    test_backpressure;
    test_illegal;
    test_settle3;
    test_reset_mid_sweep;
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
